// File: rtl/mem_port_ctrl_pkg.sv
// Shared definitions for the RAM port front end: byte-enable width, response buffer
// depth limits and occupancy counter width.
package mem_port_ctrl_pkg;

  localparam int unsigned RSP_DEPTH_MIN = 2;
  localparam int unsigned RSP_DEPTH_MAX = 16;

  function automatic int unsigned mem_be_w(int unsigned dw);
    return (dw + 7) / 8;
  endfunction

  // Wide enough to hold 0..depth inclusive.
  function automatic int unsigned occ_w(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// Register-based circular response buffer; only pointers and count are reset.
module mem_rsp_fifo
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW  = occ_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [CntW-1:0]   count,
  output logic              empty,
  output logic              full
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  assert property (@(posedge clk) disable iff (!reset_n) !(push && full));
  assert property (@(posedge clk) disable iff (!reset_n) !(pop && empty));

endmodule

// File: rtl/mem_port_ctrl.sv
// One-port request/response front end for a block RAM with fixed 1-cycle read latency.
// Requests are throttled so every outstanding read always has a buffer slot.
module mem_port_ctrl
  import mem_port_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned RSP_DEPTH = 2,
  localparam int unsigned BE_W     = mem_be_w(DATA_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BE_W-1:0]   req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned CntW = occ_w(RSP_DEPTH);

  logic              init_q;
  logic              rd_inflight_q, rd_inflight_d;
  logic              req_hs;
  logic [CntW-1:0]   fifo_count;
  logic [CntW-1:0]   occupancy;
  logic              fifo_empty, fifo_full;
  logic              fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_head;

  // Ready depends on registered state only: no path from rsp_ready.
  assign occupancy = fifo_count + CntW'(rd_inflight_q);
  assign req_ready = init_q && (occupancy < CntW'(RSP_DEPTH));
  assign req_hs    = req_valid && req_ready;

  assign mem_en   = req_hs;
  assign mem_we   = req_hs ? req_we : '0;
  assign mem_addr = req_addr;
  assign mem_din  = req_wdata;

  assign rd_inflight_d = req_hs && (req_we == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q        <= 1'b0;
      rd_inflight_q <= 1'b0;
    end else begin
      init_q        <= 1'b1;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  // Bypass: with an empty buffer the RAM output goes straight out; an unconsumed
  // beat is captured so it becomes the stable head on the next cycle.
  assign rsp_valid = !fifo_empty || rd_inflight_q;
  assign rsp_rdata = fifo_empty ? mem_dout : fifo_head;
  assign fifo_pop  = !fifo_empty && rsp_ready;
  assign fifo_push = rd_inflight_q && !(fifo_empty && rsp_ready);

  mem_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (mem_dout),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assert property (@(posedge clk) disable iff (!reset_n) fifo_full |-> !req_ready);

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural 1-cycle-latency byte-write RAM.
module tb_mem_port_ctrl;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 14;
  localparam int unsigned BW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [BW-1:0] req_we = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          mem_en;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_ctrl #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .RSP_DEPTH (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Behavioural RAM port, not reset.
  logic [DW-1:0] ram [1 << AW];
  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
    mem_dout = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == '0) mem_dout <= ram[mem_addr];
      else for (int b = 0; b < BW; b++) if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
    end
  end

  typedef struct {
    logic          vld;
    logic [BW-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rrdy;
    logic          e_rdy;
    logic          e_en;
    logic [BW-1:0] e_we;
    logic          e_rv;
    logic          chk_rd;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic vld, logic [BW-1:0] we, logic [AW-1:0] addr,
                              logic [DW-1:0] wdata, logic rrdy, logic e_rdy, logic e_en,
                              logic [BW-1:0] e_we, logic e_rv, logic chk_rd,
                              logic [DW-1:0] e_rd);
    vec_t v;
    v.vld = vld; v.we = we; v.addr = addr; v.wdata = wdata; v.rrdy = rrdy;
    v.e_rdy = e_rdy; v.e_en = e_en; v.e_we = e_we; v.e_rv = e_rv;
    v.chk_rd = chk_rd; v.e_rd = e_rd;
    return v;
  endfunction

  function automatic logic [DW-1:0] pat(int i);
    return {4{32'hC0DE_0000 | 32'(i)}};
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(logic vld, logic [BW-1:0] we, logic [AW-1:0] addr,
                       logic [DW-1:0] wdata, logic rrdy);
    req_valid = vld; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = rrdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(string tag, logic e_rdy, logic e_en, logic e_rv, logic chk_rd,
                           logic [DW-1:0] e_rd);
    @(negedge clk);
    check({tag, " req_ready"}, DW'(req_ready), DW'(e_rdy));
    check({tag, " mem_en"}, DW'(mem_en), DW'(e_en));
    check({tag, " rsp_valid"}, DW'(rsp_valid), DW'(e_rv));
    if (chk_rd) check({tag, " rsp_rdata"}, rsp_rdata, e_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] marker;
    marker = {4{32'hDEAD_BEEF}};

    // Reset held with a pending request: nothing may reach the RAM.
    drive(1'b1, '0, '0, '0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("rst%0d req_ready", c), DW'(req_ready), '0);
      check($sformatf("rst%0d mem_en", c), DW'(mem_en), '0);
      check($sformatf("rst%0d mem_we", c), DW'(mem_we), '0);
      check($sformatf("rst%0d rsp_valid", c), DW'(rsp_valid), '0);
    end
    step();
    reset_n = 1'b1;
    chk_cycle("rel0", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    drive(1'b0, '0, '0, '0, 1'b1);
    chk_cycle("rel1", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step();

    // Full write then read-back.
    tbl.push_back(mk(1, '1, 14'h10, {16{8'hA5}}, 1, 1, 1, '1, 0, 0, '0));
    tbl.push_back(mk(1, '0, 14'h10, '0, 1, 1, 1, '0, 0, 0, '0));
    tbl.push_back(mk(0, '0, '0, '0, 1, 1, 0, '0, 1, 1, {16{8'hA5}}));
    // Byte write into a zeroed word.
    tbl.push_back(mk(1, '1, 14'd5, '0, 1, 1, 1, '1, 0, 0, '0));
    tbl.push_back(mk(1, 16'h0001, 14'd5, '1, 1, 1, 1, 16'h0001, 0, 0, '0));
    tbl.push_back(mk(1, '0, 14'd5, '0, 1, 1, 1, '0, 0, 0, '0));
    tbl.push_back(mk(0, '0, '0, '0, 1, 1, 0, '0, 1, 1, DW'(128'hFF)));
    // Streaming: fill 0..15, then read back-to-back.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, '1, AW'(i), pat(i), 1, 1, 1, '1, 0, 0, '0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, '0, AW'(i), '0, 1, 1, 1, '0, i > 0, i > 0, pat(i - 1)));
    tbl.push_back(mk(0, '0, '0, '0, 1, 1, 0, '0, 1, 1, pat(15)));
    tbl.push_back(mk(0, '0, '0, '0, 1, 1, 0, '0, 0, 0, '0));

    foreach (tbl[k]) begin
      drive(tbl[k].vld, tbl[k].we, tbl[k].addr, tbl[k].wdata, tbl[k].rrdy);
      @(negedge clk);
      check($sformatf("vec%0d req_ready", k), DW'(req_ready), DW'(tbl[k].e_rdy));
      check($sformatf("vec%0d mem_en", k), DW'(mem_en), DW'(tbl[k].e_en));
      check($sformatf("vec%0d mem_we", k), DW'(mem_we), DW'(tbl[k].e_we));
      check($sformatf("vec%0d rsp_valid", k), DW'(rsp_valid), DW'(tbl[k].e_rv));
      if (tbl[k].chk_rd) check($sformatf("vec%0d rsp_rdata", k), rsp_rdata, tbl[k].e_rd);
      step();
    end

    // Backpressure: only two reads fit, data held stable until popped.
    drive(1'b1, '0, 14'd1, '0, 1'b0); chk_cycle("bp0", 1, 1, 0, 0, '0);      step();
    drive(1'b1, '0, 14'd2, '0, 1'b0); chk_cycle("bp1", 1, 1, 1, 1, pat(1)); step();
    drive(1'b1, '0, 14'd3, '0, 1'b0); chk_cycle("bp2", 0, 0, 1, 1, pat(1)); step();
    chk_cycle("bp3", 0, 0, 1, 1, pat(1)); step();
    drive(1'b1, '0, 14'd3, '0, 1'b1); chk_cycle("bp4", 0, 0, 1, 1, pat(1)); step();
    chk_cycle("bp5", 1, 1, 1, 1, pat(2)); step();
    drive(1'b0, '0, '0, '0, 1'b1);   chk_cycle("bp6", 1, 0, 1, 1, pat(3)); step();
    chk_cycle("bp7", 1, 0, 0, 0, '0); step();

    // Reset while a read is in flight.
    drive(1'b1, '1, 14'h20, marker, 1'b1); chk_cycle("mr0", 1, 1, 0, 0, '0); step();
    drive(1'b1, '0, 14'h20, '0, 1'b1);     chk_cycle("mr1", 1, 1, 0, 0, '0); step();
    drive(1'b0, '0, '0, '0, 1'b1);
    check("mr2 rsp_valid", DW'(rsp_valid), DW'(1));
    reset_n = 1'b0;
    #1;
    check("mr3 rsp_valid", DW'(rsp_valid), '0);
    check("mr3 req_ready", DW'(req_ready), '0);
    repeat (3) step();
    reset_n = 1'b1;
    chk_cycle("mr4", 0, 0, 0, 0, '0); step();
    chk_cycle("mr5", 1, 0, 0, 0, '0); step();
    chk_cycle("mr6", 1, 0, 0, 0, '0); step();
    drive(1'b1, '0, 14'h20, '0, 1'b1);     chk_cycle("mr7", 1, 1, 0, 0, '0); step();
    drive(1'b0, '0, '0, '0, 1'b1);         chk_cycle("mr8", 1, 0, 1, 1, marker); step();
    drive(1'b1, '0, 14'h10, '0, 1'b1);     chk_cycle("mr9", 1, 1, 0, 0, '0); step();
    drive(1'b0, '0, '0, '0, 1'b1);         chk_cycle("mr10", 1, 0, 1, 1, {16{8'hA5}}); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
